// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath
// for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       halted,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    state_t cur, nxt;
    logic   rtype_ok, pc_write, branch, ir_w, mem_w, reg_w, ret;

    assign rtype_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    always_comb begin
        nxt = HALT;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:
                case (opcode)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000:            nxt = rtype_ok ? EXECUTE : HALT;
                    6'b000100:            nxt = BEQ;
                    6'b001000:            nxt = ADDIEX;
                    6'b000010:            nxt = JUMP;
                    default:              nxt = HALT;
                endcase
            MEMADR:  nxt = (opcode == 6'b101011) ? MEMWR : MEMRD;
            MEMRD:   nxt = MEMWB;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP: nxt = FETCH;
            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) cur <= FETCH;
        else cur <= nxt;

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_w        = 1'b0;
        mem_w       = 1'b0;
        reg_w       = 1'b0;
        ret         = 1'b0;
        iord        = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 3'b010;
        case (cur)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_w      = 1'b1;
                pc_write  = 1'b1;
            end
            DECODE:  alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_w      = 1'b1;
                ret        = 1'b1;
            end
            MEMWR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                ret   = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = (funct == 6'b100010) ? 3'b110 :
                              (funct == 6'b100100) ? 3'b000 :
                              (funct == 6'b100101) ? 3'b001 :
                              (funct == 6'b101010) ? 3'b111 : 3'b010;
            end
            ALUWB: begin
                reg_dst = 1'b1;
                reg_w   = 1'b1;
                ret     = 1'b1;
            end
            BEQ: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch      = 1'b1;
                ret         = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_w = 1'b1;
                ret   = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                ret      = 1'b1;
            end
            default: ;
        endcase
    end

    // enables are masked during reset so an aborted instruction never writes or retires
    assign pc_en     = !reset && (pc_write || (branch && zero));
    assign ir_write  = !reset && ir_w;
    assign mem_write = !reset && mem_w;
    assign reg_write = !reset && reg_w;
    assign retire    = !reset && ret;
    assign halted    = !reset && (cur == HALT);
    assign state     = cur;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven instruction sequences with a per-cycle
// expected-output scoreboard, plus hand-written halt and async-reset cases.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       retire, halted;
    logic [3:0] state;
    logic [20:0] act;
    logic [20:0] sb[$];
    int errors = 0, checks = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
        .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
        .retire(retire), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
                  alu_src_a, alu_src_b, pc_src, alu_control, retire, halted};

    typedef struct {
        string           name;
        logic [5:0]      opcode;
        logic [5:0]      funct;
        logic            zero;
        int              ncyc;
        logic [2:0]      aluc;
        logic [4:0][3:0] path;
    } vec_t;

    vec_t vt[11];

    function automatic logic [20:0] row(input logic [3:0] s, input logic pce, irw, mw, rw,
                                        input logic io, m2r, rd, asa, input logic [1:0] asb, pcs,
                                        input logic [2:0] alc, input logic ret, hlt);
        return {s, pce, irw, mw, rw, io, m2r, rd, asa, asb, pcs, alc, ret, hlt};
    endfunction

    // expected outputs for each state, written out from the state descriptions
    function automatic logic [20:0] exp_of(input logic [3:0] s, input logic z, input logic [2:0] a);
        case (s)
            4'd0:    return row(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
            4'd1:    return row(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0);
            4'd2:    return row(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
            4'd3:    return row(3, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
            4'd4:    return row(4, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd5:    return row(5, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd6:    return row(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, a, 0, 0);
            4'd7:    return row(7, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd8:    return row(8, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0);
            4'd9:    return row(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
            4'd10:   return row(10, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd11:   return row(11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 1, 0);
            default: return row(12, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 1);
        endcase
    endfunction

    function automatic vec_t mkv(input string nm, input logic [5:0] op, fn, input logic z,
                                 input int n, input logic [2:0] a,
                                 input logic [3:0] s0, s1, s2, s3, s4);
        vec_t v;
        v.name = nm; v.opcode = op; v.funct = fn; v.zero = z; v.ncyc = n; v.aluc = a;
        v.path[0] = s0; v.path[1] = s1; v.path[2] = s2; v.path[3] = s3; v.path[4] = s4;
        return v;
    endfunction

    task automatic check(input string nm, input logic [20:0] a, input logic [20:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic check1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic push_path(input vec_t v, input int n);
        for (int c = 0; c < n; c++) sb.push_back(exp_of(v.path[c], v.zero, v.aluc));
    endtask

    task automatic run(input string nm, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL %s: scoreboard empty at cycle %0d", nm, c);
            end else check($sformatf("%s cyc%0d", nm, c + 1), act, sb.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input vec_t v);
        opcode = v.opcode; funct = v.funct; zero = v.zero;
        push_path(v, v.ncyc);
        run(v.name, v.ncyc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset outputs", act, row(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        vt[0]  = mkv("lw",    6'b100011, 6'b000000, 0, 5, 3'b010, 0, 1, 2, 3, 4);
        vt[1]  = mkv("sw",    6'b101011, 6'b000000, 0, 4, 3'b010, 0, 1, 2, 5, 0);
        vt[2]  = mkv("add",   6'b000000, 6'b100000, 0, 4, 3'b010, 0, 1, 6, 7, 0);
        vt[3]  = mkv("sub",   6'b000000, 6'b100010, 0, 4, 3'b110, 0, 1, 6, 7, 0);
        vt[4]  = mkv("and",   6'b000000, 6'b100100, 1, 4, 3'b000, 0, 1, 6, 7, 0);
        vt[5]  = mkv("or",    6'b000000, 6'b100101, 0, 4, 3'b001, 0, 1, 6, 7, 0);
        vt[6]  = mkv("slt",   6'b000000, 6'b101010, 0, 4, 3'b111, 0, 1, 6, 7, 0);
        vt[7]  = mkv("beq z1", 6'b000100, 6'b000000, 1, 3, 3'b010, 0, 1, 8, 0, 0);
        vt[8]  = mkv("beq z0", 6'b000100, 6'b000000, 0, 3, 3'b010, 0, 1, 8, 0, 0);
        vt[9]  = mkv("addi",  6'b001000, 6'b000000, 0, 4, 3'b010, 0, 1, 9, 10, 0);
        vt[10] = mkv("j",     6'b000010, 6'b000000, 0, 3, 3'b010, 0, 1, 11, 0, 0);

        #2;
        do_reset();
        for (int i = 0; i < 11; i++) apply(vt[i]);

        // illegal opcode: DECODE -> HALT, then stuck with all enables low
        opcode = 6'b111111; funct = 6'b000000;
        push_path(mkv("ill", 6'b111111, 6'b0, 0, 2, 3'b010, 0, 1, 0, 0, 0), 2);
        run("illegal op", 2);
        opcode = 6'b100011;
        for (int c = 0; c < 22; c++) sb.push_back(exp_of(12, 0, 3'b010));
        run("halt op", 22);
        do_reset();

        opcode = 6'b000000; funct = 6'b000111;
        push_path(mkv("badf", 6'b0, 6'b000111, 0, 2, 3'b010, 0, 1, 0, 0, 0), 2);
        run("illegal funct", 2);
        zero = 1'b1;
        for (int c = 0; c < 21; c++) sb.push_back(exp_of(12, 1, 3'b010));
        run("halt funct", 21);
        do_reset();

        // alu_control follows funct and pc_en follows zero within a cycle
        opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
        push_path(vt[2], 2);
        run("comb add", 2);
        @(negedge clk);
        check("exec add", act, exp_of(6, 0, 3'b010));
        funct = 6'b100100;
        #1 check("exec funct->and", act, exp_of(6, 0, 3'b000));
        @(posedge clk); #1;
        push_path(vt[2], 0);
        sb.push_back(exp_of(7, 0, 3'b010));
        run("comb aluwb", 1);
        opcode = 6'b000100; zero = 1'b0;
        push_path(vt[8], 2);
        run("comb beq", 2);
        @(negedge clk);
        check1("beq pc_en z0", pc_en, 1'b0);
        zero = 1'b1;
        #1 check1("beq pc_en z1", pc_en, 1'b1);
        @(posedge clk); #1;

        // async reset during MEMRD of lw aborts it with no write or retire
        opcode = 6'b100011; zero = 1'b0;
        push_path(vt[0], 4);
        run("abort lw", 3);
        @(negedge clk);
        check("memrd", act, sb.pop_front());
        #2 reset = 1'b1;
        #1 check("async reset", act, row(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0));
        @(posedge clk); #1;
        check1("abort reg_write", reg_write, 1'b0);
        check1("abort retire", retire, 1'b0);
        check("held reset", act, row(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0));
        reset = 1'b0;
        apply(vt[0]);
        apply(vt[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
